// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a DEPTH-entry word FIFO; frames go out back-to-back
// while words are queued. Data width, parity and stop bits are parameters.
//
// state   | meaning
// S_IDLE  | line high, waiting for a queued word
// S_START | start bit (line low)
// S_DATA  | data bits, LSB first
// S_PAR   | parity bit (only when PARITY != 0)
// S_STOP  | STOP_BITS stop bits (line high)
module uart_tx_fifo #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int UART_BPS  = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   wr_en,
    input  logic [DATA_BITS-1:0]   wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   tx_busy,
    output logic                   uart_txd
);
    localparam int BAUD_DIV = CLK_FREQ / UART_BPS;
    localparam int AW       = $clog2(DEPTH);
    localparam int LW       = AW + 1;
    localparam int BW       = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    state_t               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 wr_acc, pop;
    logic [DATA_BITS-1:0] head;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign overflow = wr_en && full;
    assign tx_busy  = (state_q != S_IDLE);
    assign uart_txd = txd_q;
    assign wr_acc   = wr_en && !full;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(wr_acc) - LW'(pop);
    end

    // Bit timer is a down-counter reloaded with BAUD_LAST; zero marks the end of a bit.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        txd_d   = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (!empty) pop = 1'b1;
            end
            S_START: begin
                if (baud_q == '0) begin
                    state_d = S_DATA;
                    baud_d  = BAUD_LAST;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_LAST;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_PAR: begin
                if (baud_q == '0) begin
                    state_d = S_STOP;
                    baud_d  = BAUD_LAST;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_STOP: begin
                if (baud_q == '0) begin
                    if (bit_q == STOP_LAST) begin
                        if (!empty) pop = 1'b1;
                        else        state_d = S_IDLE;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        baud_d = BAUD_LAST;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pop from IDLE or from the last stop bit starts the next frame with no gap.
        if (pop) begin
            state_d = S_START;
            baud_d  = BAUD_LAST;
            shift_d = head;
            par_d   = (PARITY == 1) ? ~^head : ^head;
        end

        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            S_PAR:   txd_d = par_d;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            txd_q    <= txd_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based FIFO/timing model plus a
// serial line receiver, and two 7-bit/2-stop instances for the parity variants.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int DEPTH = 4;
    localparam int BD    = 10;
    localparam int FL    = 10 * BD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       full, empty, overflow, busy, txd;
    logic [2:0] level;

    logic       wr7 = 1'b0;
    logic [6:0] d7 = '0;
    logic       full_e, empty_e, ovf_e, busy_e, txd_e;
    logic       full_o, empty_o, ovf_o, busy_o, txd_o;
    logic [2:0] level_e, level_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] m_q[$];
    logic [7:0] exp_tx[$];
    int         exp_start[$];
    int         m_free_at = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_last = '0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .DEPTH(DEPTH)) dut (
        .sys_clk(clk), .sys_rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .tx_busy(busy), .uart_txd(txd));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(7),
                   .PARITY(2), .STOP_BITS(2), .DEPTH(DEPTH)) dut_e (
        .sys_clk(clk), .sys_rst(rst), .wr_en(wr7), .wr_data(d7),
        .full(full_e), .empty(empty_e), .level(level_e), .overflow(ovf_e),
        .tx_busy(busy_e), .uart_txd(txd_e));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(7),
                   .PARITY(1), .STOP_BITS(2), .DEPTH(DEPTH)) dut_o (
        .sys_clk(clk), .sys_rst(rst), .wr_en(wr7), .wr_data(d7),
        .full(full_o), .empty(empty_o), .level(level_o), .overflow(ovf_o),
        .tx_busy(busy_o), .uart_txd(txd_o));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Model: a word is popped whenever one is stored and the previous frame has ended.
    task automatic model_proc;
        int pre;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_q.delete();
                exp_tx.delete();
                exp_start.delete();
                m_free_at = 0;
            end else begin
                pre = m_q.size();
                if (pre > 0 && cyc >= m_free_at) begin
                    exp_tx.push_back(m_q.pop_front());
                    exp_start.push_back(cyc);
                    m_free_at = cyc + FL;
                end
                if (wr_en && pre < DEPTH) m_q.push_back(wr_data);
            end
        end
    endtask

    task automatic mon_proc;
        logic e_full, e_empty, e_busy, e_ovf;
        forever begin
            @(negedge clk);
            if (!rst) begin
                e_full  = (m_q.size() == DEPTH);
                e_empty = (m_q.size() == 0);
                e_busy  = (m_free_at > cyc);
                e_ovf   = wr_en && e_full;
                checks++;
                if (level !== 3'(m_q.size()) || full !== e_full || empty !== e_empty ||
                    busy !== e_busy || overflow !== e_ovf || (!e_busy && txd !== 1'b1)) begin
                    errors++;
                    $display("FAIL monitor cyc=%0d level=%0d exp=%0d full=%b exp=%b empty=%b exp=%b busy=%b exp=%b ovf=%b exp=%b txd=%b",
                             cyc, level, m_q.size(), full, e_full, empty, e_empty, busy, e_busy, overflow, e_ovf, txd);
                end
            end
        end
    endtask

    // Receiver samples mid-bit; start time is compared with the model's pop edge.
    task automatic rx_proc;
        bit         act = 0;
        int         t = 0, st = 0, k;
        logic [7:0] d = '0;
        logic [7:0] ed;
        int         es;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 0;
            end else if (!act) begin
                if (txd === 1'b0) begin
                    act = 1;
                    t   = 0;
                    st  = cyc;
                end
            end else begin
                t++;
                if (t % BD == BD / 2) begin
                    k = t / BD;
                    if (k == 0) begin
                        checks++;
                        if (txd !== 1'b0) begin
                            errors++;
                            $display("FAIL rx_start cyc=%0d txd=%b exp=0", cyc, txd);
                        end
                    end else if (k <= 8) begin
                        d = {txd, d[7:1]};
                    end else begin
                        act = 0;
                        rx_cnt++;
                        rx_last = d;
                        checks++;
                        if (exp_tx.size() == 0) begin
                            errors++;
                            $display("FAIL rx_frame unexpected frame data=%h", d);
                        end else begin
                            ed = exp_tx.pop_front();
                            es = exp_start.pop_front();
                            if (d !== ed || st != es || txd !== 1'b1) begin
                                errors++;
                                $display("FAIL rx_frame data=%h exp=%h start=%0d exp=%0d stop=%b exp=1",
                                         d, ed, st, es, txd);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic drain(output bit ok);
        for (int i = 0; i < 700 && (m_q.size() != 0 || exp_tx.size() != 0 || busy !== 1'b0); i++) tick;
        ok = (m_q.size() == 0 && exp_tx.size() == 0 && busy === 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || empty !== 1'b1 || full !== 1'b0 ||
            level !== 3'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset txd=%b busy=%b empty=%b full=%b level=%0d ovf=%b exp 1,0,1,0,0,0",
                     txd, busy, empty, full, level, overflow);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single;
        int n, c0;
        c0 = rx_cnt;
        wr_data = 8'hA5;
        wr_en   = 1'b1;
        tick;
        wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_pre txd=%b busy=%b exp 1,0", txd, busy);
        end
        @(negedge clk);
        checks++;
        if (txd !== 1'b0 || busy !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL single_start txd=%b busy=%b empty=%b exp 0,1,1", txd, busy, empty);
        end
        n = 1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        checks++;
        if (n != FL) begin
            errors++;
            $display("FAIL single_busy_len got=%0d exp=%0d", n, FL);
        end
        checks++;
        if (rx_cnt != c0 + 1 || rx_last !== 8'hA5) begin
            errors++;
            $display("FAIL single_rx frames=%0d exp=%0d data=%h exp=a5", rx_cnt - c0, 1, rx_last);
        end
    endtask

    task automatic test_back_to_back;
        int c0;
        c0 = rx_cnt;
        wr_en   = 1'b1;
        wr_data = 8'h00; tick;
        wr_data = 8'hFF; tick;
        wr_data = 8'h02; tick;
        wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (level !== 3'd2) begin
            errors++;
            $display("FAIL b2b_level got=%0d exp=2", level);
        end
        for (int i = 0; i < 400 && rx_cnt < c0 + 3; i++) tick;
        checks++;
        if (rx_cnt != c0 + 3 || rx_last !== 8'h02) begin
            errors++;
            $display("FAIL b2b_frames got=%0d exp=3 last=%h exp=02", rx_cnt - c0, rx_last);
        end
    endtask

    task automatic test_overflow;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'($urandom);
            wr_en   = 1'b1;
            tick;
        end
        wr_data = 8'($urandom);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || full !== 1'b1 || level !== 3'd4) begin
            errors++;
            $display("FAIL ovf_pulse ovf=%b full=%b level=%0d exp 1,1,4", overflow, full, level);
        end
        tick;
        wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0 || level !== 3'd4) begin
            errors++;
            $display("FAIL ovf_after ovf=%b level=%0d exp 0,4", overflow, level);
        end
        for (int i = 0; i < 300; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_data = 8'($urandom);
            tick;
        end
        wr_en = 1'b0;
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ovf_drain queued=%0d pending=%0d busy=%b exp 0,0,0", m_q.size(), exp_tx.size(), busy);
        end
    endtask

    task automatic test_parity;
        logic [6:0] sh;
        logic       eb_e, eb_o;
        for (int r = 0; r < 2; r++) begin
            d7  = (r == 0) ? 7'h55 : 7'($urandom);
            sh  = d7;
            wr7 = 1'b1;
            tick;
            wr7 = 1'b0;
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (txd_e !== 1'b0 || txd_o !== 1'b0 || empty_e !== 1'b1 || empty_o !== 1'b1 ||
                level_e !== 3'd0 || level_o !== 3'd0 || full_e !== 1'b0 || full_o !== 1'b0 ||
                ovf_e !== 1'b0 || ovf_o !== 1'b0) begin
                errors++;
                $display("FAIL par_start txd_e=%b txd_o=%b empty=%b%b level=%0d/%0d exp txd 0, empty 1, level 0",
                         txd_e, txd_o, empty_e, empty_o, level_e, level_o);
            end
            repeat (5) @(negedge clk);
            for (int k = 0; k < 11; k++) begin
                if (k == 0) begin
                    eb_e = 1'b0;
                end else if (k <= 7) begin
                    eb_e = sh[0];
                    sh   = sh >> 1;
                end else if (k == 8) begin
                    eb_e = ($countones(d7) % 2) == 1;
                end else begin
                    eb_e = 1'b1;
                end
                eb_o = (k == 8) ? ~eb_e : eb_e;
                checks++;
                if (txd_e !== eb_e || txd_o !== eb_o) begin
                    errors++;
                    $display("FAIL par_bit data=%h bit=%0d even=%b exp=%b odd=%b exp=%b", d7, k, txd_e, eb_e, txd_o, eb_o);
                end
                if (k < 10) repeat (BD) @(negedge clk);
            end
            repeat (4) @(negedge clk);
            checks++;
            if (busy_e !== 1'b1 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL par_len_end busy=%b%b exp 11 at cycle 109", busy_e, busy_o);
            end
            @(negedge clk);
            checks++;
            if (busy_e !== 1'b0 || busy_o !== 1'b0 || txd_e !== 1'b1 || txd_o !== 1'b1) begin
                errors++;
                $display("FAIL par_len_idle busy=%b%b txd=%b%b exp 00,11 at cycle 110", busy_e, busy_o, txd_e, txd_o);
            end
            tick;
        end
    endtask

    task automatic test_reset_mid;
        int c0;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'($urandom);
            wr_en   = 1'b1;
            tick;
        end
        wr_en = 1'b0;
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || level !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid txd=%b busy=%b level=%0d empty=%b full=%b exp 1,0,0,1,0",
                     txd, busy, level, empty, full);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick;
        c0      = rx_cnt;
        wr_data = 8'h3C;
        wr_en   = 1'b1;
        tick;
        wr_en = 1'b0;
        for (int i = 0; i < 200 && rx_cnt < c0 + 1; i++) tick;
        checks++;
        if (rx_cnt != c0 + 1 || rx_last !== 8'h3C) begin
            errors++;
            $display("FAIL rst_after frames=%0d exp=1 data=%h exp=3c", rx_cnt - c0, rx_last);
        end
    endtask

    task automatic test_wr_pop_same;
        int c0;
        bit ok;
        c0 = rx_cnt;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'($urandom);
            wr_en   = 1'b1;
            tick;
        end
        wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (level !== 3'd3) begin
            errors++;
            $display("FAIL wp_level_pre got=%0d exp=3", level);
        end
        for (int i = 0; i < 200 && cyc < m_free_at - 1; i++) tick;
        wr_data = 8'($urandom);
        wr_en   = 1'b1;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0 || level !== 3'd3) begin
            errors++;
            $display("FAIL wp_before ovf=%b level=%0d exp 0,3", overflow, level);
        end
        tick;
        wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (level !== 3'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wp_after level=%0d busy=%b exp 3,1", level, busy);
        end
        drain(ok);
        checks++;
        if (!ok || rx_cnt != c0 + 5) begin
            errors++;
            $display("FAIL wp_order drained=%b frames=%0d exp=5", ok, rx_cnt - c0);
        end
    endtask

    initial begin
        fork
            model_proc();
            mon_proc();
            rx_proc();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_parity();
        test_reset_mid();
        test_wr_pop_same();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
